// File: rtl/scfifo_pkg.sv
// scfifo_pkg: shared defaults for the 288-bit x 128-entry single-clock FIFO
package scfifo_pkg;
  localparam int FIFO_WIDTH    = 288;
  localparam int FIFO_DEPTH    = 128;
  localparam int FIFO_AF_VALUE = 112;
  localparam int FIFO_PTR_W    = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/scfifo_288inx128_if.sv
// scfifo_288inx128_if: write/read handshake and status bundle of the FIFO
interface scfifo_288inx128_if
  import scfifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);
  logic [WIDTH-1:0]       data;
  logic                   wrreq;
  logic                   rdreq;
  logic [WIDTH-1:0]       q;
  logic                   empty;
  logic                   full;
  logic                   almost_full;
  logic [$clog2(DEPTH):0] usedw;
  modport master (output data, wrreq, rdreq, input q, empty, full, almost_full, usedw);
  modport slave (input data, wrreq, rdreq, output q, empty, full, almost_full, usedw);
endinterface

// File: rtl/fifo_ram_288x128.sv
// fifo_ram_288x128: simple dual-port storage with a registered read port, block-RAM inferable
module fifo_ram_288x128
  import scfifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/scfifo_288inx128.sv
// scfifo_288inx128: single-clock FIFO, 1-cycle read latency, registered empty/full/almost_full
module scfifo_288inx128
  import scfifo_pkg::*;
#(
  parameter int WIDTH             = FIFO_WIDTH,
  parameter int DEPTH             = FIFO_DEPTH,
  parameter int ALMOST_FULL_VALUE = FIFO_AF_VALUE
) (
  input logic               clock,
  input logic               sclr,
  scfifo_288inx128_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      usedw_q, usedw_d;
  logic             empty_q, empty_d, full_q, full_d, af_q, af_d, qv_q, qv_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] ram_q;
  always_comb begin
    wr_en   = f.wrreq & ~full_q & ~sclr;
    rd_en   = f.rdreq & ~empty_q & ~sclr;
    wptr_d  = wptr_q + AW'(wr_en);
    rptr_d  = rptr_q + AW'(rd_en);
    usedw_d = (wr_en && !rd_en) ? usedw_q + 1'b1 :
              (rd_en && !wr_en) ? usedw_q - 1'b1 : usedw_q;
    empty_d = usedw_d == '0;
    full_d  = usedw_d == (AW + 1)'(DEPTH);
    af_d    = usedw_d >= (AW + 1)'(ALMOST_FULL_VALUE);
    qv_d    = qv_q | rd_en;
  end
  always_ff @(posedge clock or posedge sclr) begin
    if (sclr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usedw_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      qv_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usedw_q <= usedw_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      qv_q    <= qv_d;
    end
  end
  fifo_ram_288x128 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clock), .we(wr_en), .waddr(wptr_q), .wdata(f.data),
    .re(rd_en), .raddr(rptr_q), .rdata(ram_q)
  );
  // The RAM output register has no reset; qv_q masks it to zero until a read lands after reset.
  assign f.q           = qv_q ? ram_q : '0;
  assign f.usedw       = usedw_q;
  assign f.empty       = empty_q;
  assign f.full        = full_q;
  assign f.almost_full = af_q;
endmodule

// File: tb/tb_scfifo_288inx128.sv
// tb_scfifo_288inx128: directed self-checking bench for scfifo_288inx128
module tb_scfifo_288inx128;
  import scfifo_pkg::*;
  typedef logic [FIFO_WIDTH-1:0] word_t;
  logic clock = 1'b0;
  logic sclr = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  word_t pat;
  scfifo_288inx128_if #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) f ();
  scfifo_288inx128 dut (.clock(clock), .sclr(sclr), .f(f));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input word_t d);
    f.wrreq = w;
    f.rdreq = r;
    f.data  = d;
    @(negedge clock);
    f.wrreq = 1'b0;
    f.rdreq = 1'b0;
  endtask
  task automatic do_reset();
    sclr = 1'b1;
    #2;
    sclr = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    f.wrreq = 1'b0;
    f.rdreq = 1'b0;
    f.data  = '0;
    pat     = {9{32'hA5C3_5A3C}};
    #1 sclr = 1'b1;
    #1;
    chk("rst_usedw", word_t'(f.usedw), word_t'(0));
    chk("rst_empty", word_t'(f.empty), word_t'(1));
    chk("rst_full", word_t'(f.full), word_t'(0));
    chk("rst_af", word_t'(f.almost_full), word_t'(0));
    chk("rst_q", f.q, word_t'(0));
    f.wrreq = 1'b1;
    f.data  = word_t'(32'h55);
    @(negedge clock);
    chk("rst_wr_ignored", word_t'(f.usedw), word_t'(0));
    f.wrreq = 1'b0;
    sclr    = 1'b0;
    @(negedge clock);
    // three writes then three reads
    cyc(1'b1, 1'b0, word_t'(1));
    cyc(1'b1, 1'b0, word_t'(2));
    cyc(1'b1, 1'b0, word_t'(3));
    chk("b3_usedw", word_t'(f.usedw), word_t'(3));
    chk("b3_empty", word_t'(f.empty), word_t'(0));
    cyc(1'b0, 1'b1, '0);
    chk("b3_q1", f.q, word_t'(1));
    cyc(1'b0, 1'b1, '0);
    chk("b3_q2", f.q, word_t'(2));
    cyc(1'b0, 1'b1, '0);
    chk("b3_q3", f.q, word_t'(3));
    chk("b3_empty_end", word_t'(f.empty), word_t'(1));
    cyc(1'b0, 1'b0, '0);
    chk("b3_q_hold", f.q, word_t'(3));
    // almost_full threshold
    do_reset();
    for (int i = 1; i <= 111; i++) cyc(1'b1, 1'b0, word_t'(i));
    chk("af_111", word_t'(f.almost_full), word_t'(0));
    cyc(1'b1, 1'b0, word_t'(112));
    chk("af_112", word_t'(f.almost_full), word_t'(1));
    chk("af_usedw", word_t'(f.usedw), word_t'(112));
    cyc(1'b0, 1'b1, '0);
    chk("af_drop", word_t'(f.almost_full), word_t'(0));
    chk("af_q", f.q, word_t'(1));
    // fill to full, overflow attempts, drain in order
    do_reset();
    for (int i = 0; i < 127; i++) cyc(1'b1, 1'b0, word_t'(32'h100 + i));
    chk("full_127", word_t'(f.full), word_t'(0));
    cyc(1'b1, 1'b0, word_t'(32'h17f));
    chk("full_128", word_t'(f.full), word_t'(1));
    chk("full_usedw", word_t'(f.usedw), word_t'(128));
    cyc(1'b1, 1'b0, word_t'(32'h180));
    cyc(1'b1, 1'b0, word_t'(32'h181));
    chk("full_ovf_usedw", word_t'(f.usedw), word_t'(128));
    cyc(1'b1, 1'b1, word_t'(32'hdead));
    chk("full_wr_rd_usedw", word_t'(f.usedw), word_t'(127));
    chk("full_wr_rd_q", f.q, word_t'(32'h100));
    chk("full_wr_rd_full", word_t'(f.full), word_t'(0));
    for (int i = 1; i < 128; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("drain_q", f.q, word_t'(32'h100 + i));
    end
    chk("drain_empty", word_t'(f.empty), word_t'(1));
    chk("drain_usedw", word_t'(f.usedw), word_t'(0));
    cyc(1'b0, 1'b1, '0);
    chk("udf_q_hold", f.q, word_t'(32'h17f));
    // read on empty with a simultaneous write
    cyc(1'b1, 1'b1, pat);
    chk("rw_empty_q", f.q, word_t'(32'h17f));
    chk("rw_empty_usedw", word_t'(f.usedw), word_t'(1));
    chk("rw_empty_empty", word_t'(f.empty), word_t'(0));
    cyc(1'b0, 1'b1, '0);
    chk("rw_empty_rd", f.q, pat);
    chk("rw_empty_end", word_t'(f.empty), word_t'(1));
    // steady state at 50 entries across pointer wrap
    do_reset();
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, word_t'(32'h1000 + i));
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b1, word_t'(32'h1000 + 50 + i));
      chk("wrap_q", f.q, word_t'(32'h1000 + i));
      chk("wrap_usedw", word_t'(f.usedw), word_t'(50));
    end
    // asynchronous reset with 60 entries stored
    do_reset();
    for (int i = 0; i < 61; i++) cyc(1'b1, 1'b0, word_t'(32'h2000 + i));
    cyc(1'b0, 1'b1, '0);
    chk("arst_pre_q", f.q, word_t'(32'h2000));
    chk("arst_pre_usedw", word_t'(f.usedw), word_t'(60));
    #2 sclr = 1'b1;
    #1;
    chk("arst_usedw", word_t'(f.usedw), word_t'(0));
    chk("arst_empty", word_t'(f.empty), word_t'(1));
    chk("arst_q", f.q, word_t'(0));
    chk("arst_af", word_t'(f.almost_full), word_t'(0));
    sclr = 1'b0;
    @(negedge clock);
    cyc(1'b1, 1'b0, word_t'(32'h77));
    chk("arst_wr_empty", word_t'(f.empty), word_t'(0));
    chk("arst_wr_usedw", word_t'(f.usedw), word_t'(1));
    cyc(1'b0, 1'b1, '0);
    chk("arst_rd_q", f.q, word_t'(32'h77));
    chk("arst_rd_empty", word_t'(f.empty), word_t'(1));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
